// File: rtl/stm_pkg.sv
// Shared definitions for the two-phase alternating state machine and its decoder.
// Both the encoder and the decoder call the step/unstep functions, so the arithmetic is defined in one place.
package stm_pkg;

  localparam logic PHASE_A = 1'b0;
  localparam logic PHASE_B = 1'b1;

  // Callers size-cast in and out of this width. Supported data widths are up to 64 bits.
  localparam int STM_MAXW = 64;
  typedef logic [STM_MAXW-1:0] stm_word_t;

  function automatic stm_word_t step_a(input stm_word_t r, input stm_word_t din);
    return r + din;
  endfunction

  function automatic stm_word_t step_b(input stm_word_t r, input stm_word_t din);
    return r ^ din;
  endfunction

  function automatic stm_word_t unstep_a(input stm_word_t r_next, input stm_word_t r);
    return r_next - r;
  endfunction

  function automatic stm_word_t unstep_b(input stm_word_t r_next, input stm_word_t r);
    return r_next ^ r;
  endfunction

endpackage

// File: rtl/stm_fifo.sv
// Circular-buffer FIFO. A word pushed in cycle t is visible at the head in cycle t+1.
// A push is dropped when the FIFO is full, and a pop is dropped when it is empty.
module stm_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset because the head output is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/stm_decoder.sv
// Recovers the input words of the add/xor alternating machine from its observed r samples.
// Each word appears on dout one cycle after its sample is accepted. obs_ready is low while the FIFO is full.
module stm_decoder
  import stm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             obs_valid,
  output logic             obs_ready,
  input  logic [WIDTH-1:0] obs,
  input  logic             sync,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             phase,
  output logic             primed,
  output logic [31:0]      decoded_count
);

  logic             phase_q, phase_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] word;
  logic             obs_fire, push, pop, full, empty;

  // Ready depends only on the registered FIFO fill level, never on dout_ready.
  assign obs_ready     = ~full;
  assign obs_fire      = obs_valid & obs_ready;
  assign pop           = dout_valid & dout_ready;
  assign push          = obs_fire & primed_q & ~sync;
  assign dout_valid    = ~empty;
  assign phase         = phase_q;
  assign primed        = primed_q;
  assign decoded_count = cnt_q;

  always_comb begin
    phase_d  = phase_q;
    primed_d = primed_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    word     = (phase_q == PHASE_A)
             ? WIDTH'(unstep_a(STM_MAXW'(obs), STM_MAXW'(prev_q)))
             : WIDTH'(unstep_b(STM_MAXW'(obs), STM_MAXW'(prev_q)));
    if (obs_fire) prev_d = obs;
    // On sync, a sample accepted in the same cycle becomes the new phase-A start value.
    if (sync) begin
      primed_d = obs_fire;
      phase_d  = PHASE_A;
    end else if (obs_fire) begin
      if (primed_q) begin
        phase_d = ~phase_q;
        cnt_d   = cnt_q + 32'd1;
      end else begin
        primed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q  <= PHASE_A;
      primed_q <= 1'b0;
      prev_q   <= '0;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      primed_q <= primed_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  stm_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_i     (push),
    .push_dat_i (word),
    .pop_i      (pop),
    .head_dat_o (dout),
    .full_o     (full),
    .empty_o    (empty)
  );

endmodule

// File: tb/tb_stm_decoder.sv
// Bench for stm_decoder: a vector table, hand-written corner sequences, and random traffic
// produced by a forward model of the add/xor encoder.
module tb_stm_decoder;

  localparam int W = 32;
  localparam int D = 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic         obs_valid, sync, dout_ready;
  logic [W-1:0] obs;
  logic         obs_ready, dout_valid, phase, primed;
  logic [W-1:0] dout;
  logic [31:0]  decoded_count;

  int n_checks = 0;
  int n_fail   = 0;

  stm_decoder #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .obs_valid     (obs_valid),
    .obs_ready     (obs_ready),
    .obs           (obs),
    .sync          (sync),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout          (dout),
    .phase         (phase),
    .primed        (primed),
    .decoded_count (decoded_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [31:0] o;
    logic        s;
    logic        r;
    logic        edv;
    logic [31:0] ed;
    logic        ery;
    logic        eph;
    logic        epr;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #3;
    RST = 1'b0;
    tick();
  endtask

  // State of the random encoder model.
  logic [31:0] expq[$];
  logic [31:0] got[$];
  logic        m_started, m_phase, m_need, m_fire, m_pop;
  logic [31:0] enc_r, off_obs, off_in;
  int          m_pushes, idx;
  logic [31:0] seq[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_valid = 1'b0; sync = 1'b0; dout_ready = 1'b0; obs = '0; RST = 1'b0;
    #2;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk("reset dout_valid", 32'(dout_valid), 32'd0);
    chk("reset dout", dout, 32'd0);
    chk("reset count", decoded_count, 32'd0);
    chk("reset phase", 32'(phase), 32'd0);
    chk("reset primed", 32'(primed), 32'd0);
    chk("reset obs_ready", 32'(obs_ready), 32'd1);

    // Vector table: inputs applied for one edge, then outputs checked.
    tv[0]  = '{1'b1, 32'd0,         1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0};
    tv[1]  = '{1'b1, 32'd5,         1'b0, 1'b1, 1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 32'd1};
    tv[2]  = '{1'b1, 32'd2,         1'b0, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 32'd2};
    tv[3]  = '{1'b1, 32'd5,         1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 1'b1, 1'b1, 32'd3};
    tv[4]  = '{1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd3};
    tv[5]  = '{1'b1, 32'hFFFFFFFF,  1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd3};
    tv[6]  = '{1'b1, 32'd1,         1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 1'b1, 1'b1, 32'd4};
    tv[7]  = '{1'b1, 32'd3,         1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0, 1'b1, 32'd5};
    tv[8]  = '{1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5};
    tv[9]  = '{1'b1, 32'd0,         1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd5};
    tv[10] = '{1'b1, 32'd5,         1'b0, 1'b0, 1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 32'd6};
    tv[11] = '{1'b1, 32'd10,        1'b1, 1'b0, 1'b1, 32'd5, 1'b1, 1'b0, 1'b1, 32'd6};
    tv[12] = '{1'b1, 32'd14,        1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b1, 1'b1, 32'd7};
    tv[13] = '{1'b0, 32'd0,         1'b0, 1'b1, 1'b1, 32'd4, 1'b1, 1'b1, 1'b1, 32'd7};
    tv[14] = '{1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd7};
    for (int i = 0; i < 15; i++) begin
      obs_valid = tv[i].v; obs = tv[i].o; sync = tv[i].s; dout_ready = tv[i].r;
      tick();
      chk($sformatf("row%0d dout_valid", i), 32'(dout_valid), 32'(tv[i].edv));
      if (tv[i].edv) chk($sformatf("row%0d dout", i), dout, tv[i].ed);
      chk($sformatf("row%0d obs_ready", i), 32'(obs_ready), 32'(tv[i].ery));
      chk($sformatf("row%0d phase", i), 32'(phase), 32'(tv[i].eph));
      chk($sformatf("row%0d primed", i), 32'(primed), 32'(tv[i].epr));
      chk($sformatf("row%0d count", i), decoded_count, tv[i].ecnt);
    end
    obs_valid = 1'b0; sync = 1'b0;

    // Backpressure: the FIFO fills, the 4th sample stalls, then the FIFO drains in order.
    do_reset();
    seq[0] = 32'd0; seq[1] = 32'd5; seq[2] = 32'd2; seq[3] = 32'd5;
    idx = 0; dout_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      obs_valid = (idx < 4); obs = seq[idx % 4];
      m_fire = obs_valid & obs_ready;
      tick();
      if (m_fire) idx++;
    end
    chk("bp obs_ready low", 32'(obs_ready), 32'd0);
    chk("bp samples taken", 32'(idx), 32'd3);
    chk("bp count", decoded_count, 32'd2);
    chk("bp head", dout, 32'd5);
    got.delete();
    dout_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      obs_valid = (idx < 4); obs = seq[idx % 4];
      m_fire = obs_valid & obs_ready;
      if (dout_valid) got.push_back(dout);
      tick();
      if (m_fire) idx++;
    end
    obs_valid = 1'b0;
    chk("bp drained words", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("bp word0", got[0], 32'd5);
      chk("bp word1", got[1], 32'd7);
      chk("bp word2", got[2], 32'd3);
    end

    // Reset mid-stream with two words held. After draining, prev=5 and phase=B.
    dout_ready = 1'b0;
    obs_valid = 1'b1; obs = 32'd7; tick();
    obs = 32'd8; tick();
    obs_valid = 1'b0;
    chk("mid full", 32'(obs_ready), 32'd0);
    chk("mid head", dout, 32'd2);
    #2 RST = 1'b1;
    #1;
    chk("mid rst dout_valid", 32'(dout_valid), 32'd0);
    chk("mid rst count", decoded_count, 32'd0);
    chk("mid rst primed", 32'(primed), 32'd0);
    RST = 1'b0;
    dout_ready = 1'b1;
    obs_valid = 1'b1; obs = 32'd0; tick();
    obs = 32'd9; tick();
    obs_valid = 1'b0;
    chk("post rst dout_valid", 32'(dout_valid), 32'd1);
    chk("post rst dout", dout, 32'd9);

    // Random traffic checked against a forward-encoder model.
    do_reset();
    expq.delete();
    m_started = 1'b0; m_phase = 1'b0; m_need = 1'b1; m_pushes = 0;
    enc_r = '0; off_obs = '0; off_in = '0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd obs_ready", 32'(obs_ready), 32'(expq.size() != D));
      chk("rnd dout_valid", 32'(dout_valid), 32'(expq.size() > 0));
      if (expq.size() > 0) chk("rnd dout", dout, expq[0]);
      chk("rnd phase", 32'(phase), 32'(m_phase));
      chk("rnd primed", 32'(primed), 32'(m_started));
      chk("rnd count", decoded_count, 32'(m_pushes));
      sync = ($urandom_range(0, 15) == 0);
      if (sync) begin
        m_started = 1'b0; m_phase = 1'b0; m_need = 1'b1;
      end
      if (m_need) begin
        if (!m_started) begin
          off_obs = $urandom;
        end else begin
          off_in  = $urandom;
          off_obs = m_phase ? (enc_r ^ off_in) : (enc_r + off_in);
        end
        m_need = 1'b0;
      end
      obs = off_obs;
      obs_valid = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      m_fire = obs_valid && (expq.size() != D);
      m_pop = (expq.size() > 0) && dout_ready;
      tick();
      if (m_pop) void'(expq.pop_front());
      if (m_fire) begin
        if (m_started) begin
          expq.push_back(off_in);
          m_pushes++;
          m_phase = ~m_phase;
        end
        m_started = 1'b1;
        enc_r = off_obs;
        m_need = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stm_decoder.md
Name: stm_decoder

Overview:
Receive-side companion to the two-phase alternating state machine. That machine drives r each cycle; its phase alternates A,B,A,... starting at A from reset.
- Phase A update: r_next = r + in (mod 2^WIDTH).
- Phase B update: r_next = r ^ in.
This block observes the stream of r samples and recovers the original in words, then buffers them in a small FIFO behind a valid/ready output.

Parameters:
WIDTH, 32, data width of observed r and recovered in
DEPTH, 2, output FIFO entries; power of two, >= 2

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  asynchronous, active-high reset
obs_valid  input  1  obs holds a new r sample
obs_ready  output  1  decoder can accept a sample
obs  input  WIDTH  observed r value
sync  input  1  resynchronise: next accepted sample is a phase-A start value
dout_valid  output  1  FIFO head is valid
dout_ready  input  1  consumer takes FIFO head
dout  output  WIDTH  recovered in word (FIFO head)
phase  output  1  0 = next transition decoded as A (add), 1 = B (xor)
primed  output  1  a previous sample is held
decoded_count  output  32  number of words pushed into the FIFO, wraps mod 2^32

Behaviour:
- Reset (async, RST=1): phase=0, primed=0, prev=0, FIFO empty, dout_valid=0, dout=0, decoded_count=0, obs_ready=1 once RST is released. Reset mid-stream discards all buffered words and the held sample.
- Handshake: obs_fire = obs_valid & obs_ready. pop = dout_valid & dout_ready. obs_ready = (count != DEPTH), i.e. not full.
  - A full FIFO does not accept, even when a pop occurs in the same cycle; no combinational ready path from dout_ready.
- Decode on obs_fire with primed=0 (priming sample): prev<=obs, primed<=1. No FIFO push; phase unchanged.
- Decode on obs_fire with primed=1:
  - word = (phase==0) ? (obs - prev) mod 2^WIDTH : (obs ^ prev).
  - Push word; prev<=obs; phase<=~phase; decoded_count++.
- Latency: a word decoded from the sample accepted in cycle t is visible on dout/dout_valid in cycle t+1.
- sync=1 (independent of obs_valid): primed<=0, phase<=0. The FIFO is untouched.
  - If sync and obs_fire occur in the same cycle, obs is the priming sample: prev<=obs, primed<=1, phase<=0, no push.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count (0..DEPTH); pointers wrap at DEPTH.
  - Push and pop in the same cycle when not full: count unchanged, both pointers advance.
  - dout shows the head entry whenever count>0; dout holds its value while dout_valid=1 and dout_ready=0.
- Arithmetic: subtraction is WIDTH-bit modular; no overflow flag.
- decoded_count wraps from 0xFFFFFFFF to 0.

Decomposition:
- Package stm_pkg:
  - Phase encoding constants PHASE_A=1'b0, PHASE_B=1'b1 (shared with the state machine).
  - Functions step_a/step_b (forward) and unstep_a/unstep_b (inverse), so encoder and decoder share one definition.
- Sub-module stm_fifo (WIDTH, DEPTH): push/pop, full/empty, count. The decoder core holds prev/phase/primed and decode logic only.

Test Plan:
- Basic decode: after reset, feed obs 0,5,2,5 (one per cycle, dout_ready=1) -> dout 5,7,3, each one cycle after its sample; decoded_count=3; phase=1.
- Modular subtract: feed priming 0xFFFFFFFF, then 0x00000001 with phase=0 -> dout=0x00000002. Next obs 0x00000003 (phase B) -> dout=0x00000002.
- Backpressure: DEPTH=2, dout_ready=0, feed 0,5,2,5:
  - obs_ready drops after the 2nd word is pushed, and the 4th sample is held.
  - Raise dout_ready -> outputs 5,7,3 in order; no loss or duplication.
- Sync: after 0,5 (word 5 out), assert sync with obs=10, then obs 14 -> dout=4 (add), phase=1. The FIFO word 5 is still delivered first if not yet popped.
- Reset mid-stream: FIFO holding 2 words, pulse RST between edges -> dout_valid=0, decoded_count=0, primed=0 immediately. Then 0,9 -> dout=9.
- Simultaneous push/pop: stream continuously with dout_ready=1 -> count stays at 1 and dout_valid stays high from the second decoded word onward.
